fuse_ctrl_edn_arb: RTL



---
 rtl/caliptra_otp_ctrl_pkg.sv | 26 ++
 rtl/fuse_ctrl_edn_arb_if.sv | 38 +++
 rtl/fuse_ctrl_edn_rr_pick.sv | 28 ++
 rtl/fuse_ctrl_edn_arb.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/caliptra_otp_ctrl_pkg.sv
// Shared fuse-controller definitions used by the EDN arbiter: consumer indices,
// EDN word/length/timeout constants and the arbiter state encoding.
package caliptra_otp_ctrl_pkg;

  typedef enum logic [1:0] {
    EdnLfsr  = 2'd0,
    EdnKey   = 2'd1,
    EdnNonce = 2'd2
  } edn_consumer_e;

  localparam int EdnNumReq         = 3;
  localparam int EdnWordW          = 32;
  localparam int EdnMaxWords       = 8;
  localparam int EdnTimeoutDefault = 1024;

  typedef enum logic {
    StIdle = 1'b0,
    StXfer = 1'b1
  } edn_arb_state_e;

  // Width of a per-consumer word count able to hold 0..max_words.
  function automatic int edn_len_w(input int max_words);
    return $clog2(max_words + 1);
  endfunction

endpackage

// File: rtl/fuse_ctrl_edn_arb_if.sv
// Consumer request/response bundle plus the EDN req/ack port of the arbiter.
// Handshake: edn_req_o is a level held for the whole grant; each cycle with
// edn_ack_i high while granted transfers one word, rsp_valid_o pulses one cycle later.
interface fuse_ctrl_edn_arb_if
  import caliptra_otp_ctrl_pkg::*;
#(
  parameter int NumReq   = EdnNumReq,
  parameter int WordW    = EdnWordW,
  parameter int MaxWords = EdnMaxWords
);
  localparam int LenW = edn_len_w(MaxWords);

  logic [NumReq-1:0]      req_i;
  logic [NumReq*LenW-1:0] req_len_i;
  logic [NumReq-1:0]      gnt_o;
  logic [NumReq-1:0]      rsp_valid_o;
  logic [WordW-1:0]       rsp_bits_o;
  logic                   rsp_fips_o;
  logic [NumReq-1:0]      done_o;
  logic [NumReq-1:0]      err_o;
  logic                   edn_req_o;
  logic                   edn_ack_i;
  logic [WordW-1:0]       edn_bits_i;
  logic                   edn_fips_i;

  // Consumers and the EDN source.
  modport master (
    output req_i, req_len_i, edn_ack_i, edn_bits_i, edn_fips_i,
    input  gnt_o, rsp_valid_o, rsp_bits_o, rsp_fips_o, done_o, err_o, edn_req_o
  );

  // The arbiter.
  modport slave (
    input  req_i, req_len_i, edn_ack_i, edn_bits_i, edn_fips_i,
    output gnt_o, rsp_valid_o, rsp_bits_o, rsp_fips_o, done_o, err_o, edn_req_o
  );

endinterface

// File: rtl/fuse_ctrl_edn_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module fuse_ctrl_edn_rr_pick #(
  parameter int NumReq = 3
) (
  input  logic [NumReq-1:0]         req,
  input  logic [$clog2(NumReq)-1:0] ptr,
  output logic [NumReq-1:0]         onehot,
  output logic [$clog2(NumReq)-1:0] idx
);
  localparam int IdxW = $clog2(NumReq);

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    onehot = '0;
    idx    = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      int j;
      j = int'(ptr) + i;
      if (j >= NumReq) j = j - NumReq;
      if (req[j]) begin
        onehot    = '0;
        onehot[j] = 1'b1;
        idx       = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/fuse_ctrl_edn_arb.sv
// Shares the single EDN port between fuse-controller consumers: round-robin grant,
// multi-word EDN req/ack sequencing, registered word return and a stall watchdog.
module fuse_ctrl_edn_arb
  import caliptra_otp_ctrl_pkg::*;
#(
  parameter int NumReq        = EdnNumReq,
  parameter int WordW         = EdnWordW,
  parameter int MaxWords      = EdnMaxWords,
  parameter int TimeoutCycles = EdnTimeoutDefault
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  fuse_ctrl_edn_arb_if.slave    bus,
  output edn_arb_state_e        dbg_state
);
  localparam int LenW = edn_len_w(MaxWords);
  localparam int IdxW = $clog2(NumReq);
  localparam int WdW  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

  edn_arb_state_e    state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [IdxW-1:0]   rr_q, rr_d;
  logic [LenW-1:0]   cnt_q, cnt_d;
  logic [WdW-1:0]    wd_q, wd_d;
  logic [NumReq-1:0] gnt_q, gnt_d;
  logic [NumReq-1:0] rsp_valid_q, rsp_valid_d;
  logic [WordW-1:0]  rsp_bits_q, rsp_bits_d;
  logic              rsp_fips_q, rsp_fips_d;
  logic [NumReq-1:0] done_q, done_d;
  logic [NumReq-1:0] err_q, err_d;
  logic              edn_req_q, edn_req_d;

  logic [NumReq-1:0] pick_onehot;
  logic [IdxW-1:0]   pick_idx;
  logic [LenW-1:0]   len_sel;
  logic [LenW-1:0]   len_clamped;

  fuse_ctrl_edn_rr_pick #(.NumReq(NumReq)) u_pick (
    .req    (bus.req_i),
    .ptr    (rr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  assign len_sel     = bus.req_len_i[int'(pick_idx)*LenW +: LenW];
  assign len_clamped = (len_sel > LenW'(MaxWords)) ? LenW'(MaxWords) : len_sel;

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] k);
    return (k == IdxW'(NumReq - 1)) ? '0 : k + IdxW'(1);
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    wd_d        = wd_q;
    gnt_d       = gnt_q;
    rsp_valid_d = '0;
    rsp_bits_d  = rsp_bits_q;
    rsp_fips_d  = rsp_fips_q;
    done_d      = '0;
    err_d       = '0;
    edn_req_d   = edn_req_q;

    case (state_q)
      StIdle: begin
        gnt_d     = '0;
        edn_req_d = 1'b0;
        if (|bus.req_i) begin
          idx_d = pick_idx;
          gnt_d = pick_onehot;
          wd_d  = '0;
          cnt_d = len_clamped;
          if (len_clamped == '0) begin
            // Zero-length grant completes without touching EDN.
            done_d = pick_onehot;
            rr_d   = next_idx(pick_idx);
          end else begin
            edn_req_d = 1'b1;
            state_d   = StXfer;
          end
        end
      end

      StXfer: begin
        if (bus.edn_ack_i) begin
          rsp_valid_d = gnt_q;
          rsp_bits_d  = bus.edn_bits_i;
          rsp_fips_d  = bus.edn_fips_i;
          cnt_d       = cnt_q - LenW'(1);
          // The cycle after an ack already counts as one cycle of waiting.
          wd_d        = WdW'(1);
          if (cnt_q == LenW'(1)) begin
            done_d    = gnt_q;
            gnt_d     = '0;
            edn_req_d = 1'b0;
            rr_d      = next_idx(idx_q);
            state_d   = StIdle;
          end
        end else if ((TimeoutCycles > 0) && (wd_q == WdW'(TimeoutCycles))) begin
          err_d     = gnt_q;
          gnt_d     = '0;
          edn_req_d = 1'b0;
          cnt_d     = '0;
          rr_d      = next_idx(idx_q);
          state_d   = StIdle;
        end else if (TimeoutCycles > 0) begin
          wd_d = wd_q + WdW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      rr_q        <= '0;
      cnt_q       <= '0;
      wd_q        <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_bits_q  <= '0;
      rsp_fips_q  <= 1'b0;
      done_q      <= '0;
      err_q       <= '0;
      edn_req_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      wd_q        <= wd_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_bits_q  <= rsp_bits_d;
      rsp_fips_q  <= rsp_fips_d;
      done_q      <= done_d;
      err_q       <= err_d;
      edn_req_q   <= edn_req_d;
    end
  end

  assign bus.gnt_o       = gnt_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_bits_o  = rsp_bits_q;
  assign bus.rsp_fips_o  = rsp_fips_q;
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;
  assign bus.edn_req_o   = edn_req_q;
  assign dbg_state       = state_q;

endmodule
